// File: rtl/fp_regfile_sb_pkg.sv
// Shared constants and clear-FSM state encoding for the FP register file.
package fp_rf_pkg;
  localparam int FP_DATA_W = 32;
  localparam int FP_ADDR_W = 5;
  localparam int FP_N_RD   = 3;

  typedef enum logic {RF_IDLE, RF_SWEEP} rf_clr_state_t;
endpackage

// File: rtl/fp_regfile_sb_if.sv
// Issue/writeback-side bundle for the FP register file: reads, pending lookups, write, issue, clear.
interface fp_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 3
);
  logic [N_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [N_RD-1:0][DATA_W-1:0] rd_data;
  logic [N_RD-1:0]             rd_pending;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        issue_en;
  logic [ADDR_W-1:0]           issue_addr;
  logic                        clr_req;
  logic                        clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, clr_req,
    input  rd_data, rd_pending, clr_busy
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, clr_req,
    output rd_data, rd_pending, clr_busy
  );
endinterface

// File: rtl/fp_regfile_sb_scoreboard.sv
// Per-register pending bits: set on issue, cleared by writeback or clear-all, looked up per read port.
module fp_rf_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int N_RD   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  logic                        issue_en_i,
  input  logic [ADDR_W-1:0]           issue_addr_i,
  input  logic                        clr_all_i,
  input  logic [N_RD-1:0][ADDR_W-1:0] rd_addr_i,
  output logic [N_RD-1:0]             rd_pending_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;

  // Issue is applied after the writeback clear so a same-address producer stays pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_all_i) begin
      pend_d = '0;
    end else begin
      if (wr_en_i)    pend_d[wr_addr_i]    = 1'b0;
      if (issue_en_i) pend_d[issue_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  for (genvar g = 0; g < N_RD; g++) begin : g_lookup
    assign rd_pending_o[g] = pend_q[rd_addr_i[g]] && !(wr_en_i && wr_addr_i == rd_addr_i[g]);
  end
endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file: N bypassed read ports, one write port, scoreboard, and a one-entry-per-cycle clear sweep.
module fp_regfile_sb
  import fp_rf_pkg::*;
#(
  parameter int DATA_W = FP_DATA_W,
  parameter int ADDR_W = FP_ADDR_W,
  parameter int N_RD   = FP_N_RD
) (
  input  logic           clk,
  input  logic           reset,
  fp_regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  rf_clr_state_t                state_q;
  logic [ADDR_W-1:0]            idx_q;
  logic                         busy_q;
  logic                         clr_all;

  assign clr_all      = (state_q == RF_IDLE) && bus.clr_req;
  assign bus.clr_busy = busy_q;

  // The writeback assignment comes last so it beats the sweep zero on the same entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q   <= '0;
      state_q <= RF_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: if (bus.clr_req) begin
          state_q <= RF_SWEEP;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
        RF_SWEEP: begin
          mem_q[idx_q] <= '0;
          idx_q        <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= RF_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= RF_IDLE;
      endcase
      if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    assign bus.rd_data[g] = (bus.wr_en && bus.wr_addr == bus.rd_addr[g]) ? bus.wr_data
                                                                         : mem_q[bus.rd_addr[g]];
  end

  fp_rf_scoreboard #(.ADDR_W(ADDR_W), .N_RD(N_RD)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (bus.wr_en),
    .wr_addr_i   (bus.wr_addr),
    .issue_en_i  (bus.issue_en),
    .issue_addr_i(bus.issue_addr),
    .clr_all_i   (clr_all),
    .rd_addr_i   (bus.rd_addr),
    .rd_pending_o(bus.rd_pending)
  );
endmodule
